rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between the single-cycle ALU/load writeback path and a multi-cycle multiply/divide unit (MDU).
- Keeps a 32-entry busy scoreboard for MDU destinations and stalls the core on RAW, WAW and issue hazards against them.
- Buffers MDU results in a small FIFO; drains them on cycles when the ALU is not writing.
- Sits between the decode/writeback logic and the register file's regWr/Rw/busW inputs.

Parameters:
DATA_W, 32, datapath width
ADDR_W, 5, register index width (32 registers)
FIFO_DEPTH, 2, MDU result buffer entries (power of two, ≥2)
STARVE_LIMIT, 4, consecutive blocked cycles before a forced drain

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
alu_wr_en  in  1  ALU/load writeback request this cycle
alu_rw  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU writeback data (link value already formed upstream)
ra  in  ADDR_W  decode source register A
rb  in  ADDR_W  decode source register B
issue_valid  in  1  decode wants to issue an MDU op this cycle
issue_rw  in  ADDR_W  MDU op destination register
md_valid  in  1  MDU result available
md_rw  in  ADDR_W  MDU result destination
md_data  in  DATA_W  MDU result value
md_ready  out  1  FIFO can accept an MDU result
rf_regWr  out  1  register file write enable
rf_Rw  out  ADDR_W  register file write address
rf_busW  out  DATA_W  register file write data
stall  out  1  core must hold the PC/decode and suppress alu_wr_en
busy_vec  out  32  scoreboard, for debug

Behaviour:
- Reset (async, while rst=1):
  - FIFO empty, busy_vec=0, starvation counter=0.
  - Outputs: rf_regWr=0, rf_Rw=0, rf_busW=0, md_ready=0, stall=0.
- md_ready = !full (registered state only; does not depend on a same-cycle pop).
- MDU accept: md_valid && md_ready pushes {md_rw, md_data}.
  - md_rw=0 is accepted and discarded (no push).
- Write port mux (combinational; the register file captures on the same posedge):
  - alu_wr_en=1 → rf_regWr=1, rf_Rw=alu_rw, rf_busW=alu_data. The ALU always wins. Its writeback cannot be delayed, even if it arrives while stall=1 (contract violation, flagged by the bench, no data loss).
  - Else FIFO non-empty → write the FIFO head and pop it at the clock edge.
  - Else rf_regWr=0; rf_Rw and rf_busW hold their last driven values.
- Scoreboard:
  - Set: busy[issue_rw] is set at the clock edge when issue_valid && !stall && issue_rw≠0.
  - Clear: busy[head.rw] is cleared on the clock edge that commits that FIFO head.
  - The set and clear conditions can never target the same register in one cycle, because issue to a busy register stalls.
  - busy[0] is always 0.
- stall = force_drain OR any of:
  - busy[ra]
  - busy[rb]
  - alu_wr_en && busy[alu_rw] (WAW)
  - issue_valid && busy[issue_rw]
- Register 0 never causes a stall.
- No forwarding from the FIFO: a RAW hazard stalls until the commit has happened. Stall drops the cycle after the commit edge.
- Starvation:
  - The counter increments each cycle the FIFO is non-empty and alu_wr_en=1.
  - It resets to 0 on any pop or when the FIFO is empty.
  - force_drain is a registered flag, set when the counter reaches STARVE_LIMIT and cleared on the next pop.
- FIFO full + md_valid: md_ready=0; the MDU must hold its result. There is no overflow path.
- Push and pop in the same cycle (not full): both occur; occupancy is unchanged.
- Reset mid-operation: pending FIFO results and busy bits are lost. The core is also reset, so no architectural state is depended on.

Test Plan:
- Reset checks:
  - Assert rst mid-cycle with the FIFO holding one entry → rf_regWr, md_ready and stall are 0 immediately.
  - busy_vec=0 while reset is held.
  - After release: md_ready=1, and the FIFO does not drain.
- Issue/commit and RAW stall:
  - issue_valid, issue_rw=8 → busy_vec[8]=1 next cycle.
  - ra=8 → stall=1.
  - md_valid, md_rw=8, md_data=0x1234 with alu_wr_en=0 → write to R8 with 0x1234 one cycle after the push.
  - busy_vec[8]=0 and stall=0 the following cycle.
- Contention:
  - FIFO holds {R9, 0xAAAA}.
  - alu_wr_en=1, alu_rw=3, alu_data=0x55 → rf writes R3=0x55; the FIFO is untouched.
  - Next idle cycle → R9=0xAAAA.
- Starvation:
  - FIFO non-empty, alu_wr_en=1 for 4 cycles → stall=1 on cycle 5.
  - Bench drops alu_wr_en → head drains; stall falls the next cycle.
- Full FIFO:
  - Two results are buffered while the ALU writes continuously → md_ready=0.
  - A third md_valid is held and not lost, and is accepted once a pop occurs.
- Register zero and WAW:
  - md_rw=0 → no write, no stall.
  - With R5 busy, alu_wr_en to R5 → stall=1.
  - issue_valid to R5 → stall=1 and busy is not re-set.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port between the single-cycle
// ALU/load writeback path and a multi-cycle MDU. MDU results are buffered in a
// small FIFO and drained on cycles when the ALU is idle. A busy scoreboard of
// outstanding MDU destinations stalls the core on RAW/WAW/issue hazards, and a
// starvation counter forces a drain when the ALU monopolises the port.
module rf_wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_wr_en,
  input  logic [ADDR_W-1:0] alu_rw,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rw,
  input  logic              md_valid,
  input  logic [ADDR_W-1:0] md_rw,
  input  logic [DATA_W-1:0] md_data,
  output logic              md_ready,
  output logic              rf_regWr,
  output logic [ADDR_W-1:0] rf_Rw,
  output logic [DATA_W-1:0] rf_busW,
  output logic              stall,
  output logic [31:0]       busy_vec
);

  localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  // FIFO storage and bookkeeping
  logic [ADDR_W-1:0] fifoRw   [FIFO_DEPTH];
  logic [DATA_W-1:0] fifoData [FIFO_DEPTH];
  logic [PTR_W-1:0]  rdPtrR;
  logic [PTR_W-1:0]  wrPtrR;
  logic [CNT_W-1:0]  countR;
  logic [CNT_W-1:0]  countNextS;
  logic              mdReadyR;

  // Scoreboard, starvation tracking and last-driven write port values
  logic [31:0]       busyR;
  logic [31:0]       busyNextS;
  logic [STV_W-1:0]  starveR;
  logic [STV_W-1:0]  starveNextS;
  logic              forceDrainR;
  logic [ADDR_W-1:0] lastRwR;
  logic [DATA_W-1:0] lastDataR;

  logic              emptyS;
  logic              pushS;
  logic              popS;
  logic              issueS;
  logic              stallS;
  logic [ADDR_W-1:0] headRwS;
  logic [DATA_W-1:0] headDataS;

  assign headRwS   = fifoRw[rdPtrR];
  assign headDataS = fifoData[rdPtrR];
  assign md_ready  = mdReadyR;
  assign busy_vec  = busyR;
  assign stall     = stallS;

  // FIFO handshake decode and next occupancy; a zero destination is swallowed
  always_comb begin
    emptyS = (countR == {CNT_W{1'b0}});
    pushS  = md_valid && mdReadyR && (md_rw != {ADDR_W{1'b0}});
    popS   = !alu_wr_en && !emptyS;
    case ({pushS, popS})
      2'b10:   countNextS = countR + CNT_W'(1);
      2'b01:   countNextS = countR - CNT_W'(1);
      default: countNextS = countR;
    endcase
  end

  // Hazard detection; busy bit 0 is never set so R0 never stalls
  always_comb begin
    stallS = forceDrainR
           | busyR[ra]
           | busyR[rb]
           | (alu_wr_en & busyR[alu_rw])
           | (issue_valid & busyR[issue_rw]);
    issueS = issue_valid && !stallS && (issue_rw != {ADDR_W{1'b0}});
  end

  // Scoreboard next state: set on accepted issue, clear on commit of the head
  always_comb begin
    busyNextS = 32'd0;
    for (int i = 1; i < 32; i++) begin
      busyNextS[i] = (busyR[i] | (issueS && (issue_rw == ADDR_W'(i))))
                   & ~(popS && (headRwS == ADDR_W'(i)));
    end
  end

  // Starvation counter next state: counts cycles a waiting result loses the port
  always_comb begin
    if (popS || emptyS) begin
      starveNextS = {STV_W{1'b0}};
    end else if (alu_wr_en && (starveR != STV_W'(STARVE_LIMIT))) begin
      starveNextS = starveR + STV_W'(1);
    end else begin
      starveNextS = starveR;
    end
  end

  // Write port mux: ALU has absolute priority, otherwise drain the FIFO head
  always_comb begin
    if (rst) begin
      rf_regWr = 1'b0;
      rf_Rw    = lastRwR;
      rf_busW  = lastDataR;
    end else if (alu_wr_en) begin
      rf_regWr = 1'b1;
      rf_Rw    = alu_rw;
      rf_busW  = alu_data;
    end else if (!emptyS) begin
      rf_regWr = 1'b1;
      rf_Rw    = headRwS;
      rf_busW  = headDataS;
    end else begin
      rf_regWr = 1'b0;
      rf_Rw    = lastRwR;
      rf_busW  = lastDataR;
    end
  end

  // FIFO pointers, occupancy and registered ready flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPtrR   <= {PTR_W{1'b0}};
      wrPtrR   <= {PTR_W{1'b0}};
      countR   <= {CNT_W{1'b0}};
      mdReadyR <= 1'b0;
    end else begin
      if (pushS) begin
        wrPtrR <= (wrPtrR == PTR_W'(FIFO_DEPTH - 1)) ? {PTR_W{1'b0}} : wrPtrR + PTR_W'(1);
      end
      if (popS) begin
        rdPtrR <= (rdPtrR == PTR_W'(FIFO_DEPTH - 1)) ? {PTR_W{1'b0}} : rdPtrR + PTR_W'(1);
      end
      countR   <= countNextS;
      mdReadyR <= (countNextS != CNT_W'(FIFO_DEPTH));
    end
  end

  // FIFO payload storage; contents are meaningless while the FIFO is empty
  always_ff @(posedge clk) begin
    if (pushS) begin
      fifoRw[wrPtrR]   <= md_rw;
      fifoData[wrPtrR] <= md_data;
    end
  end

  // Scoreboard, starvation counter and forced-drain flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busyR       <= 32'd0;
      starveR     <= {STV_W{1'b0}};
      forceDrainR <= 1'b0;
    end else begin
      busyR   <= busyNextS;
      starveR <= starveNextS;
      if (popS) begin
        forceDrainR <= 1'b0;
      end else if (starveNextS == STV_W'(STARVE_LIMIT)) begin
        forceDrainR <= 1'b1;
      end
    end
  end

  // Remember the last address/data driven so idle cycles hold them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lastRwR   <= {ADDR_W{1'b0}};
      lastDataR <= {DATA_W{1'b0}};
    end else if (rf_regWr) begin
      lastRwR   <= rf_Rw;
      lastDataR <= rf_busW;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Testbench for rf_wb_arbiter: a directed vector table covering issue/commit,
// contention, starvation, full FIFO, R0 and WAW, a hand-written reset sequence,
// then randomized traffic checked against a queue-based reference model.
module tb_rf_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic          clk;
  logic          rst;
  logic          alu_wr_en;
  logic [AW-1:0] alu_rw;
  logic [DW-1:0] alu_data;
  logic [AW-1:0] ra;
  logic [AW-1:0] rb;
  logic          issue_valid;
  logic [AW-1:0] issue_rw;
  logic          md_valid;
  logic [AW-1:0] md_rw;
  logic [DW-1:0] md_data;
  logic          md_ready;
  logic          rf_regWr;
  logic [AW-1:0] rf_Rw;
  logic [DW-1:0] rf_busW;
  logic          stall;
  logic [31:0]   busy_vec;

  int errors = 0;
  int checks = 0;

  rf_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .alu_wr_en(alu_wr_en), .alu_rw(alu_rw), .alu_data(alu_data),
    .ra(ra), .rb(rb),
    .issue_valid(issue_valid), .issue_rw(issue_rw),
    .md_valid(md_valid), .md_rw(md_rw), .md_data(md_data),
    .md_ready(md_ready),
    .rf_regWr(rf_regWr), .rf_Rw(rf_Rw), .rf_busW(rf_busW),
    .stall(stall), .busy_vec(busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          aluEn;
    logic [AW-1:0] aluRw;
    logic [DW-1:0] aluData;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic          iv;
    logic [AW-1:0] irw;
    logic          mv;
    logic [AW-1:0] mrw;
    logic [DW-1:0] mdata;
    logic          eWr;
    logic [AW-1:0] eRw;
    logic [DW-1:0] eBusW;
    logic          eStall;
    logic          eReady;
    logic [31:0]   eBusy;
  } vec_t;

  typedef struct {
    logic [AW-1:0] rw;
    logic [DW-1:0] d;
  } ent_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic aluEn, logic [AW-1:0] aluRw, logic [DW-1:0] aluData,
                              logic [AW-1:0] ra_, logic [AW-1:0] rb_,
                              logic iv, logic [AW-1:0] irw,
                              logic mv, logic [AW-1:0] mrw, logic [DW-1:0] mdata,
                              logic eWr, logic [AW-1:0] eRw, logic [DW-1:0] eBusW,
                              logic eStall, logic eReady, logic [31:0] eBusy);
    vec_t v;
    v.aluEn = aluEn; v.aluRw = aluRw; v.aluData = aluData;
    v.ra = ra_; v.rb = rb_; v.iv = iv; v.irw = irw;
    v.mv = mv; v.mrw = mrw; v.mdata = mdata;
    v.eWr = eWr; v.eRw = eRw; v.eBusW = eBusW;
    v.eStall = eStall; v.eReady = eReady; v.eBusy = eBusy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic aluEn, input logic [AW-1:0] aluRw, input logic [DW-1:0] aluData,
                       input logic [AW-1:0] ra_, input logic [AW-1:0] rb_,
                       input logic iv, input logic [AW-1:0] irw,
                       input logic mv, input logic [AW-1:0] mrw, input logic [DW-1:0] mdata);
    alu_wr_en = aluEn; alu_rw = aluRw; alu_data = aluData;
    ra = ra_; rb = rb_; issue_valid = iv; issue_rw = irw;
    md_valid = mv; md_rw = mrw; md_data = mdata;
  endtask

  // Reference model state
  ent_t          q[$];
  bit            busyM[32];
  int            starveM;
  bit            fdM;
  bit            readyM;
  logic [AW-1:0] lastRwM;
  logic [DW-1:0] lastDM;
  logic [AW-1:0] mduQ[$];

  function automatic logic [31:0] busyVecM();
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < 32; i++) v[i] = busyM[i];
    return v;
  endfunction

  function automatic bit stallM(logic aluEn, logic [AW-1:0] aluRw, logic [AW-1:0] ra_,
                                logic [AW-1:0] rb_, logic iv, logic [AW-1:0] irw);
    return fdM || busyM[ra_] || busyM[rb_] || (aluEn && busyM[aluRw]) || (iv && busyM[irw]);
  endfunction

  initial begin
    logic          aluEn, iv, mdHeld;
    logic [AW-1:0] aluRw, ra_, rb_, irw, mdRw;
    logic [DW-1:0] aluData, mdData;
    bit            st, wasEmpty, popM;
    logic          eWr;
    logic [AW-1:0] eRw;
    logic [DW-1:0] eBusW;
    ent_t          e;

    rst = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    #1;
    chk("reset_regWr", {31'd0, rf_regWr}, 32'd0);
    chk("reset_ready", {31'd0, md_ready}, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_busy", busy_vec, 32'd0);
    chk("reset_Rw", {27'd0, rf_Rw}, 32'd0);
    chk("reset_busW", rf_busW, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // ---------------- directed vector table ----------------
    //              aluEn aluRw aluData      ra    rb    iv    irw   mv    mrw   mdata           eWr   eRw    eBusW            eSt   eRdy  eBusy
    vecs.push_back(mk(1'b0, 5'd0, 32'h0,    5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 32'h0));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0,    5'd0, 5'd0, 1'b1, 5'd8, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 32'h0));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0,    5'd8, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0,  32'h0,    1'b1, 1'b1, 32'h100));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0,    5'd8, 5'd0, 1'b0, 5'd0, 1'b1, 5'd8, 32'h1234, 1'b0, 5'd0,  32'h0,    1'b1, 1'b1, 32'h100));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0,    5'd8, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b1, 5'd8,  32'h1234, 1'b1, 1'b1, 32'h100));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0,    5'd8, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b0, 5'd8,  32'h1234, 1'b0, 1'b1, 32'h0));
    // contention
    vecs.push_back(mk(1'b0, 5'd0, 32'h0,    5'd0, 5'd0, 1'b1, 5'd9, 1'b0, 5'd0, 32'h0,    1'b0, 5'd8,  32'h1234, 1'b0, 1'b1, 32'h0));
    vecs.push_back(mk(1'b1, 5'd3, 32'h55,   5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 32'hAAAA, 1'b1, 5'd3,  32'h55,   1'b0, 1'b1, 32'h200));
    vecs.push_back(mk(1'b1, 5'd3, 32'h55,   5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b1, 5'd3,  32'h55,   1'b0, 1'b1, 32'h200));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0,    5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b1, 5'd9,  32'hAAAA, 1'b0, 1'b1, 32'h200));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0,    5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b0, 5'd9,  32'hAAAA, 1'b0, 1'b1, 32'h0));
    // starvation
    vecs.push_back(mk(1'b0, 5'd0, 32'h0,    5'd0, 5'd0, 1'b1, 5'd10,1'b0, 5'd0, 32'h0,    1'b0, 5'd9,  32'hAAAA, 1'b0, 1'b1, 32'h0));
    vecs.push_back(mk(1'b1, 5'd1, 32'h11,   5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd10,32'hBEEF, 1'b1, 5'd1,  32'h11,   1'b0, 1'b1, 32'h400));
    vecs.push_back(mk(1'b1, 5'd2, 32'h22,   5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b1, 5'd2,  32'h22,   1'b0, 1'b1, 32'h400));
    vecs.push_back(mk(1'b1, 5'd3, 32'h33,   5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b1, 5'd3,  32'h33,   1'b0, 1'b1, 32'h400));
    vecs.push_back(mk(1'b1, 5'd4, 32'h44,   5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b1, 5'd4,  32'h44,   1'b0, 1'b1, 32'h400));
    vecs.push_back(mk(1'b1, 5'd6, 32'h56,   5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b1, 5'd6,  32'h56,   1'b0, 1'b1, 32'h400));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0,    5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b1, 5'd10, 32'hBEEF, 1'b1, 1'b1, 32'h400));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0,    5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b0, 5'd10, 32'hBEEF, 1'b0, 1'b1, 32'h0));
    // full FIFO
    vecs.push_back(mk(1'b0, 5'd0, 32'h0,    5'd0, 5'd0, 1'b1, 5'd11,1'b0, 5'd0, 32'h0,    1'b0, 5'd10, 32'hBEEF, 1'b0, 1'b1, 32'h0));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0,    5'd0, 5'd0, 1'b1, 5'd12,1'b0, 5'd0, 32'h0,    1'b0, 5'd10, 32'hBEEF, 1'b0, 1'b1, 32'h800));
    vecs.push_back(mk(1'b1, 5'd6, 32'h66,   5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd11,32'h1111, 1'b1, 5'd6,  32'h66,   1'b0, 1'b1, 32'h1800));
    vecs.push_back(mk(1'b1, 5'd7, 32'h77,   5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd12,32'h2222, 1'b1, 5'd7,  32'h77,   1'b0, 1'b1, 32'h1800));
    vecs.push_back(mk(1'b1, 5'd6, 32'h66,   5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd13,32'h3333, 1'b1, 5'd6,  32'h66,   1'b0, 1'b0, 32'h1800));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0,    5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd13,32'h3333, 1'b1, 5'd11, 32'h1111, 1'b0, 1'b0, 32'h1800));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0,    5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd13,32'h3333, 1'b1, 5'd12, 32'h2222, 1'b0, 1'b1, 32'h1000));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0,    5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b1, 5'd13, 32'h3333, 1'b0, 1'b1, 32'h0));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0,    5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b0, 5'd13, 32'h3333, 1'b0, 1'b1, 32'h0));
    // register zero and WAW
    vecs.push_back(mk(1'b0, 5'd0, 32'h0,    5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd13, 32'h3333, 1'b0, 1'b1, 32'h0));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0,    5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b0, 5'd13, 32'h3333, 1'b0, 1'b1, 32'h0));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0,    5'd0, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0, 32'h0,    1'b0, 5'd13, 32'h3333, 1'b0, 1'b1, 32'h0));
    vecs.push_back(mk(1'b1, 5'd5, 32'h99,   5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b1, 5'd5,  32'h99,   1'b1, 1'b1, 32'h20));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0,    5'd0, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0, 32'h0,    1'b0, 5'd5,  32'h99,   1'b1, 1'b1, 32'h20));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0,    5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 32'h0,    1'b0, 5'd5,  32'h99,   1'b0, 1'b1, 32'h20));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0,    5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 32'h5555, 1'b0, 5'd5,  32'h99,   1'b0, 1'b1, 32'h20));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0,    5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b1, 5'd5,  32'h5555, 1'b0, 1'b1, 32'h20));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0,    5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b0, 5'd5,  32'h5555, 1'b0, 1'b1, 32'h0));

    foreach (vecs[k]) begin
      drive(vecs[k].aluEn, vecs[k].aluRw, vecs[k].aluData, vecs[k].ra, vecs[k].rb,
            vecs[k].iv, vecs[k].irw, vecs[k].mv, vecs[k].mrw, vecs[k].mdata);
      #1;
      chk($sformatf("v%0d_regWr", k), {31'd0, rf_regWr}, {31'd0, vecs[k].eWr});
      chk($sformatf("v%0d_Rw", k), {27'd0, rf_Rw}, {27'd0, vecs[k].eRw});
      chk($sformatf("v%0d_busW", k), rf_busW, vecs[k].eBusW);
      chk($sformatf("v%0d_stall", k), {31'd0, stall}, {31'd0, vecs[k].eStall});
      chk($sformatf("v%0d_ready", k), {31'd0, md_ready}, {31'd0, vecs[k].eReady});
      chk($sformatf("v%0d_busy", k), busy_vec, vecs[k].eBusy);
      @(posedge clk); #1;
    end

    // ---------------- reset mid-operation ----------------
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd14, 1'b0, 5'd0, 32'h0);
    @(posedge clk); #1;
    drive(1'b1, 5'd1, 32'h101, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd14, 32'h77);
    @(posedge clk); #1;
    drive(1'b1, 5'd1, 32'h101, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("prerst_Rw", {27'd0, rf_Rw}, 32'd1);
    chk("prerst_busy", busy_vec, 32'h4000);
    #2;
    rst = 1'b1;
    alu_wr_en = 1'b0;
    #1;
    chk("midrst_regWr", {31'd0, rf_regWr}, 32'd0);
    chk("midrst_ready", {31'd0, md_ready}, 32'd0);
    chk("midrst_stall", {31'd0, stall}, 32'd0);
    chk("midrst_busy", busy_vec, 32'd0);
    @(posedge clk); #1;
    chk("heldrst_busy", busy_vec, 32'd0);
    chk("heldrst_regWr", {31'd0, rf_regWr}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("postrst_ready", {31'd0, md_ready}, 32'd1);
    chk("postrst_regWr", {31'd0, rf_regWr}, 32'd0);
    @(posedge clk); #1;
    chk("postrst_nodrain", {31'd0, rf_regWr}, 32'd0);
    chk("postrst_Rw", {27'd0, rf_Rw}, 32'd0);

    // ---------------- randomized traffic vs reference model ----------------
    q.delete();
    mduQ.delete();
    for (int i = 0; i < 32; i++) busyM[i] = 1'b0;
    starveM = 0;
    fdM = 1'b0;
    readyM = 1'b1;
    lastRwM = '0;
    lastDM = '0;
    mdHeld = 1'b0;
    mdRw = '0;
    mdData = '0;

    for (int c = 0; c < 3000; c++) begin
      aluEn   = ($urandom_range(0, 9) < 6);
      aluRw   = AW'($urandom_range(0, 31));
      aluData = $urandom;
      ra_     = AW'($urandom_range(0, 15));
      rb_     = AW'($urandom_range(0, 15));
      iv      = ($urandom_range(0, 2) == 0);
      irw     = AW'($urandom_range(0, 15));
      if (!mdHeld && (mduQ.size() > 0) && ($urandom_range(0, 1) == 1)) begin
        mdHeld = 1'b1;
        mdRw   = mduQ[0];
        mdData = $urandom;
      end
      st = stallM(aluEn, aluRw, ra_, rb_, iv, irw);
      if (st && aluEn) begin
        aluEn = 1'b0;
        st = stallM(aluEn, aluRw, ra_, rb_, iv, irw);
      end
      drive(aluEn, aluRw, aluData, ra_, rb_, iv, irw, mdHeld, mdRw, mdData);

      wasEmpty = (q.size() == 0);
      popM = !aluEn && !wasEmpty;
      if (aluEn) begin
        eWr = 1'b1; eRw = aluRw; eBusW = aluData;
      end else if (!wasEmpty) begin
        eWr = 1'b1; eRw = q[0].rw; eBusW = q[0].d;
      end else begin
        eWr = 1'b0; eRw = lastRwM; eBusW = lastDM;
      end

      #1;
      chk("rnd_regWr", {31'd0, rf_regWr}, {31'd0, eWr});
      chk("rnd_Rw", {27'd0, rf_Rw}, {27'd0, eRw});
      chk("rnd_busW", rf_busW, eBusW);
      chk("rnd_stall", {31'd0, stall}, {31'd0, st});
      chk("rnd_ready", {31'd0, md_ready}, {31'd0, readyM});
      chk("rnd_busy", busy_vec, busyVecM());

      // advance the model by one clock
      if (eWr) begin
        lastRwM = eRw;
        lastDM = eBusW;
      end
      if (popM) begin
        e = q.pop_front();
        busyM[e.rw] = 1'b0;
      end
      if (iv && !st && (irw != 5'd0)) begin
        busyM[irw] = 1'b1;
        mduQ.push_back(irw);
      end
      if (mdHeld && readyM) begin
        e.rw = mdRw;
        e.d = mdData;
        q.push_back(e);
        void'(mduQ.pop_front());
        mdHeld = 1'b0;
      end
      if (popM || wasEmpty) begin
        starveM = 0;
      end else if (aluEn && (starveM < LIMIT)) begin
        starveM = starveM + 1;
      end
      if (popM) begin
        fdM = 1'b0;
      end else if (starveM == LIMIT) begin
        fdM = 1'b1;
      end
      readyM = (q.size() < DEPTH);

      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
